// File: rtl/seq_pkg.sv
// Shared encodings and default widths for the serial
// pattern transmitter and its counters.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_REP_W   = 4;
  localparam int DEF_GAP_W   = 4;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag; load has
// priority over decrement.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern
// MSB-first, repeating with optional idle gaps.
module serial_pattern_tx
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int REP_W   = DEF_REP_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [REP_W-1:0]   repeat_cnt,
  input  logic [GAP_W-1:0]   gap,
  input  logic               abort,
  output logic               out_bit,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  state_t state, state_nxt;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_m1_q;
  logic [GAP_W-1:0]   gap_q;
  logic [REP_W-1:0]   rep_q;

  logic [LEN_W-1:0] len_clamp;
  logic [LEN_W-1:0] idx, idx_val;
  logic [GAP_W-1:0] gcnt;
  logic idx_zero, gap_zero;
  logic idx_load, idx_dec;
  logic gap_load, gap_dec;
  logic accept, last_bit, more, gap_end;
  logic bit_d, valid_d, busy_d, done_d;

  assign len_clamp = (length > LEN_W'(MAX_LEN))
                   ? LEN_W'(MAX_LEN) : length;

  // Outputs trail the state by one edge, so a start is
  // only taken once the registered busy has dropped.
  assign accept   = (state == ST_IDLE) & ~busy & start
                  & (length != '0) & ~abort;
  assign last_bit = (state == ST_SHIFT) & idx_zero;
  assign more     = (rep_q != '0);
  assign gap_end  = (state == ST_GAP) & gap_zero;

  assign idx_load = accept | gap_end
                  | (last_bit & more & (gap_q == '0));
  assign idx_val  = accept ? len_clamp - LEN_W'(1) : len_m1_q;
  assign idx_dec  = (state == ST_SHIFT) & ~idx_zero;
  assign gap_load = last_bit & more & (gap_q != '0);
  assign gap_dec  = (state == ST_GAP) & ~gap_zero;

  seq_down_counter #(.W(LEN_W)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .load     (idx_load),
    .dec      (idx_dec),
    .load_val (idx_val),
    .count    (idx),
    .zero     (idx_zero)
  );

  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .dec      (gap_dec),
    .load_val (gap_q - GAP_W'(1)),
    .count    (gcnt),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q    <= '0;
      len_m1_q <= '0;
      gap_q    <= '0;
      rep_q    <= '0;
    end else if (accept) begin
      pat_q    <= pattern;
      len_m1_q <= len_clamp - LEN_W'(1);
      gap_q    <= gap;
      rep_q    <= repeat_cnt;
    end else if (last_bit & more) begin
      rep_q    <= rep_q - REP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT:
        if (idx_zero) begin
          if (!more)
            state_nxt = ST_IDLE;
          else if (gap_q != '0)
            state_nxt = ST_GAP;
          else
            state_nxt = ST_SHIFT;
        end
      ST_GAP:
        if (gap_zero) state_nxt = ST_SHIFT;
      default:
        state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    valid_d = (state == ST_SHIFT);
    bit_d   = valid_d
            & |(pat_q & (MAX_LEN'(1) << idx));
    busy_d  = (state == ST_SHIFT) | (state == ST_GAP);
    done_d  = (state == ST_IDLE) & busy;
    if (abort) begin
      valid_d = 1'b0;
      bit_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_bit   <= bit_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  logic unused_gcnt;
  assign unused_gcnt = ^gcnt;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx; observed word is
// {out_valid, out_bit, busy, done}.
module tb_serial_pattern_tx;

  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_B1   = 4'b1110;
  localparam logic [3:0] O_B0   = 4'b1010;
  localparam logic [3:0] O_GAP  = 4'b0010;
  localparam logic [3:0] O_DONE = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] length = '0;
  logic [3:0] repeat_cnt = '0;
  logic [3:0] gap = '0;
  logic       abort = 1'b0;
  logic       out_bit, out_valid, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_pattern_tx dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .length     (length),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .abort      (abort),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [3:0] obs();
    return {out_valid, out_bit, busy, done};
  endfunction

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bits(input string tag,
                             input logic [15:0] bits,
                             input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tick();
      chk(tag, obs(), bits[i] ? O_B1 : O_B0);
    end
  endtask

  task automatic go(input logic [7:0] p, input logic [3:0] l,
                    input logic [3:0] r, input logic [3:0] g);
    pattern = p;
    length = l;
    repeat_cnt = r;
    gap = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    pattern = '0;
    length = '0;
    repeat_cnt = '0;
    gap = '0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset", obs(), O_IDLE);
    reset = 1'b0;
    tick();
    chk("idle", obs(), O_IDLE);

    go(8'b101, 4'd3, 4'd0, 4'd0);
    chk("t1_latency", obs(), O_IDLE);
    expect_bits("t1_bits", 16'b101, 3);
    tick();
    chk("t1_done", obs(), O_DONE);
    tick();
    chk("t1_after", obs(), O_IDLE);

    go(8'b101, 4'd3, 4'd2, 4'd0);
    expect_bits("t2_bits", 16'b101101101, 9);
    tick();
    chk("t2_done", obs(), O_DONE);
    tick();
    chk("t2_single_done", obs(), O_IDLE);

    go(8'b101, 4'd3, 4'd1, 4'd2);
    expect_bits("t3_pass1", 16'b101, 3);
    tick();
    chk("t3_gap1", obs(), O_GAP);
    tick();
    chk("t3_gap2", obs(), O_GAP);
    expect_bits("t3_pass2", 16'b101, 3);
    tick();
    chk("t3_done", obs(), O_DONE);
    tick();

    go(8'hFF, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_len0", obs(), O_IDLE);
    end

    go(8'b1100_1010, 4'd12, 4'd0, 4'd0);
    expect_bits("t4_clamp", 16'b1100_1010, 8);
    tick();
    chk("t4_clamp_done", obs(), O_DONE);
    tick();

    go(8'b101, 4'd3, 4'd3, 4'd0);
    expect_bits("t5_pre", 16'b10, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort", obs(), O_IDLE);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_done", obs(), O_IDLE);
    end
    abort = 1'b1;
    go(8'b101, 4'd3, 4'd0, 4'd0);
    abort = 1'b0;
    chk("t5_start_abort", obs(), O_IDLE);
    tick();
    chk("t5_start_abort2", obs(), O_IDLE);

    go(8'b101, 4'd3, 4'd1, 4'd3);
    expect_bits("t6_pass1", 16'b101, 3);
    tick();
    chk("t6_gap", obs(), O_GAP);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_reset", obs(), O_IDLE);
    tick();
    chk("t6_reset_nodone", obs(), O_IDLE);

    go(8'b101, 4'd3, 4'd0, 4'd0);
    expect_bits("t6_first", 16'b101, 3);
    tick();
    chk("t6_done", obs(), O_DONE);
    go(8'b10, 4'd2, 4'd0, 4'd0);
    chk("t6_accept", obs(), O_IDLE);
    expect_bits("t6_second", 16'b10, 2);
    tick();
    chk("t6_done2", obs(), O_DONE);
    tick();

    go(8'b1, 4'd1, 4'd15, 4'd0);
    expect_bits("max_rep", 16'hFFFF, 16);
    tick();
    chk("max_rep_done", obs(), O_DONE);
    tick();

    go(8'b1, 4'd1, 4'd1, 4'd15);
    expect_bits("max_gap_p1", 16'b1, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("max_gap_idle", obs(), O_GAP);
    end
    expect_bits("max_gap_p2", 16'b1, 1);
    tick();
    chk("max_gap_done", obs(), O_DONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
